// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Latency: none (declarations only).
// Backpressure: n/a.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    // Requester index: 0 = datapath load/store, 1 = loader/debug DMA.
    typedef logic req_id_t;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 4;

    // Wide enough to hold MEM_LAT_MAX-1.
    localparam int CNT_W = 2;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection between the two memory requesters.
// Latency: zero cycles; purely combinational.
// Backpressure: none; the caller only consults it while idle.
import mem_arb_pkg::*;

module arb_pick (
    input  logic    req0,
    input  logic    req1,
    input  req_id_t last_grant,
    input  logic    rr_en,
    output logic    any,
    output req_id_t win
);

    // Single request wins outright; a tie goes to the non-last requester in
    // round-robin mode, otherwise to requester 0.
    always_comb begin
        any = req0 | req1;
        win = 1'b0;
        if (req0 && req1) begin
            win = rr_en ? ~last_grant : 1'b0;
        end else if (req1) begin
            win = 1'b1;
        end
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Two-requester arbiter for the single data memory port; MEM_ARB_ROUND_ROBIN_EN selects round-robin ties.
// Latency: request to ack is MEM_LAT+1 cycles; one transaction per MEM_LAT+2 cycles.
// Backpressure: requesters hold req until their one-cycle ack; others wait in place.
import mem_arb_pkg::*;

module data_memory_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output req_id_t           grant_id
);

    // Out-of-range latencies are clamped to the supported 1..4 window.
    localparam int LAT = (MEM_LAT < MEM_LAT_MIN) ? MEM_LAT_MIN :
                         (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    arb_state_t       state;
    logic [CNT_W-1:0] cnt;
    req_id_t          last_grant;
    logic             any;
    req_id_t          win;

    arb_pick u_arb_pick (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant),
        .rr_en      (RR_EN),
        .any        (any),
        .win        (win)
    );

    // Arbiter FSM; the mem_* registers double as the latched transaction
    // fields, so they are loaded on grant and cleared when ACCESS ends.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            busy       <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata      <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        state      <= ACCESS;
                        cnt        <= CNT_LOAD;
                        grant_id   <= win;
                        last_grant <= win;
                        busy       <= 1'b1;
                        if (win) begin
                            mem_addr  <= addr1;
                            mem_wdata <= wdata1;
                            mem_write <= we1;
                            mem_read  <= ~we1;
                        end else begin
                            mem_addr  <= addr0;
                            mem_wdata <= wdata0;
                            mem_write <= we0;
                            mem_read  <= ~we0;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        if (mem_read) begin
                            rdata <= mem_rdata;
                        end
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        ack0      <= ~grant_id;
                        ack1      <= grant_id;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3.
// Latency: n/a.
// Backpressure: n/a.
module tb_data_memory_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: MEM_LAT = 1
    logic       a_rst, a_req0, a_req1, a_we0, a_we1;
    logic [7:0] a_addr0, a_addr1, a_wdata0, a_wdata1;
    logic       a_ack0, a_ack1, a_mem_read, a_mem_write, a_busy, a_grant_id;
    logic [7:0] a_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic [7:0] a_mem [256];

    // Instance B: MEM_LAT = 3
    logic       b_rst, b_req0, b_req1, b_we0, b_we1;
    logic [7:0] b_addr0, b_addr1, b_wdata0, b_wdata1;
    logic       b_ack0, b_ack1, b_mem_read, b_mem_write, b_busy, b_grant_id;
    logic [7:0] b_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [7:0] b_mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    data_memory_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(1)) u_lat1 (
        .clk(clk), .rst(a_rst),
        .req0(a_req0), .req1(a_req1), .we0(a_we0), .we1(a_we1),
        .addr0(a_addr0), .addr1(a_addr1), .wdata0(a_wdata0), .wdata1(a_wdata1),
        .ack0(a_ack0), .ack1(a_ack1), .rdata(a_rdata),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_rdata(a_mem_rdata),
        .busy(a_busy), .grant_id(a_grant_id)
    );

    data_memory_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(3)) u_lat3 (
        .clk(clk), .rst(b_rst),
        .req0(b_req0), .req1(b_req1), .we0(b_we0), .we1(b_we1),
        .addr0(b_addr0), .addr1(b_addr1), .wdata0(b_wdata0), .wdata1(b_wdata1),
        .ack0(b_ack0), .ack1(b_ack1), .rdata(b_rdata),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_rdata(b_mem_rdata),
        .busy(b_busy), .grant_id(b_grant_id)
    );

    // Simple synchronous-write, combinational-read memories.
    always @(posedge clk) begin
        if (a_mem_write) a_mem[a_mem_addr] <= a_mem_wdata;
    end
    assign a_mem_rdata = a_mem[a_mem_addr];

    always @(posedge clk) begin
        if (!b_rst) begin
            b_mem[8'h20] <= 8'h3C;
            b_mem[8'h05] <= 8'h5A;
            b_mem[8'h06] <= 8'h66;
        end else if (b_mem_write) begin
            b_mem[b_mem_addr] <= b_mem_wdata;
        end
    end
    assign b_mem_rdata = b_mem[b_mem_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int order[$];
        int first_ack;
        int second_ack;
        int nrd;
        int ack_at;
        int exp_id;

        a_rst = 1'b0; a_req0 = 1'b0; a_req1 = 1'b0; a_we0 = 1'b0; a_we1 = 1'b0;
        a_addr0 = 8'h00; a_addr1 = 8'h00; a_wdata0 = 8'h00; a_wdata1 = 8'h00;
        b_rst = 1'b0; b_req0 = 1'b0; b_req1 = 1'b0; b_we0 = 1'b0; b_we1 = 1'b0;
        b_addr0 = 8'h00; b_addr1 = 8'h00; b_wdata0 = 8'h00; b_wdata1 = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack0",     32'(a_ack0), 0);
        chk("rst_ack1",     32'(a_ack1), 0);
        chk("rst_rdata",    32'(a_rdata), 0);
        chk("rst_busy",     32'(a_busy), 0);
        chk("rst_grant_id", 32'(a_grant_id), 0);
        chk("rst_mem_rw",   32'({a_mem_read, a_mem_write}), 0);
        chk("rst_mem_addr", 32'(a_mem_addr), 0);
        a_rst = 1'b1;
        b_rst = 1'b1;

        // req0 writes 0xA5 to 0x10
        a_req0 = 1'b1; a_we0 = 1'b1; a_addr0 = 8'h10; a_wdata0 = 8'hA5;
        step();
        chk("wr_mem_write", 32'(a_mem_write), 1);
        chk("wr_mem_read",  32'(a_mem_read), 0);
        chk("wr_mem_addr",  32'(a_mem_addr), 'h10);
        chk("wr_mem_wdata", 32'(a_mem_wdata), 'hA5);
        chk("wr_busy",      32'(a_busy), 1);
        chk("wr_ack0_early", 32'(a_ack0), 0);
        step();
        chk("wr_ack0",      32'(a_ack0), 1);
        chk("wr_strobe_off", 32'(a_mem_write), 0);
        chk("wr_grant_id",  32'(a_grant_id), 0);
        chk("wr_rdata_kept", 32'(a_rdata), 0);
        a_req0 = 1'b0; a_we0 = 1'b0;
        step();
        chk("wr_ack0_pulse", 32'(a_ack0), 0);
        chk("wr_idle_busy", 32'(a_busy), 0);

        // req1 reads back 0x10
        a_req1 = 1'b1; a_we1 = 1'b0; a_addr1 = 8'h10;
        step();
        chk("rd_mem_read", 32'(a_mem_read), 1);
        chk("rd_mem_addr", 32'(a_mem_addr), 'h10);
        chk("rd_grant_id", 32'(a_grant_id), 1);
        step();
        chk("rd_ack1",  32'(a_ack1), 1);
        chk("rd_ack0",  32'(a_ack0), 0);
        chk("rd_rdata", 32'(a_rdata), 'hA5);
        a_req1 = 1'b0;
        step();

        // Both requesters held for four transactions; last grant was requester 1
        a_req0 = 1'b1; a_we0 = 1'b0; a_addr0 = 8'h10;
        a_req1 = 1'b1; a_we1 = 1'b0; a_addr1 = 8'h10;
        for (int c = 0; c < 12; c++) begin
            step();
            if (a_ack0) order.push_back(0);
            if (a_ack1) order.push_back(1);
        end
        a_req0 = 1'b0; a_req1 = 1'b0;
        chk("tie_count", 32'(order.size()), 4);
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_id = i % 2;
`else
            exp_id = 0;
`endif
            chk($sformatf("tie_grant%0d", i), (i < order.size()) ? 32'(order[i]) : 32'hFF, 32'(exp_id));
        end
        step();
        step();
        chk("tie_idle_busy", 32'(a_busy), 0);

        // req0 held after ack: re-granted, ack MEM_LAT+2 cycles later
        a_req0 = 1'b1; a_we0 = 1'b0; a_addr0 = 8'h10;
        first_ack = -1; second_ack = -1;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (a_ack0) begin
                if (first_ack < 0) first_ack = c;
                else if (second_ack < 0) second_ack = c;
            end
        end
        a_req0 = 1'b0;
        chk("regrant_first", 32'(first_ack), 2);
        chk("regrant_gap",   32'(second_ack - first_ack), 3);
        step();
        step();

        // MEM_LAT=3: req1 reads 0x20 holding 0x3C
        b_req1 = 1'b1; b_we1 = 1'b0; b_addr1 = 8'h20;
        nrd = 0; ack_at = -1;
        for (int c = 1; c <= 4; c++) begin
            step();
            if (b_mem_read) nrd++;
            if (b_ack1 && ack_at < 0) ack_at = c;
        end
        b_req1 = 1'b0;
        chk("lat3_read_cycles", 32'(nrd), 3);
        chk("lat3_ack_cycle",   32'(ack_at), 4);
        chk("lat3_rdata",       32'(b_rdata), 'h3C);
        step();

        // Address and req change during ACCESS are ignored
        b_req0 = 1'b1; b_we0 = 1'b0; b_addr0 = 8'h05;
        step();
        chk("lock_addr0", 32'(b_mem_addr), 'h05);
        b_addr0 = 8'h06; b_req0 = 1'b0;
        step();
        chk("lock_addr1", 32'(b_mem_addr), 'h05);
        step();
        chk("lock_addr2", 32'(b_mem_addr), 'h05);
        step();
        chk("lock_ack0",  32'(b_ack0), 1);
        chk("lock_rdata", 32'(b_rdata), 'h5A);
        step();

        // Reset in the middle of a req1 read
        b_req1 = 1'b1; b_we1 = 1'b0; b_addr1 = 8'h20;
        step();
        step();
        chk("rstmid_busy_before", 32'(b_busy), 1);
        #1 b_rst = 1'b0;
        #1;
        chk("rstmid_mem_read", 32'(b_mem_read), 0);
        chk("rstmid_mem_addr", 32'(b_mem_addr), 0);
        chk("rstmid_busy",     32'(b_busy), 0);
        chk("rstmid_ack1",     32'(b_ack1), 0);
        chk("rstmid_rdata",    32'(b_rdata), 0);
        #4 b_rst = 1'b1;
        ack_at = -1;
        for (int c = 1; c <= 4; c++) begin
            step();
            if (b_ack1 && ack_at < 0) ack_at = c;
        end
        b_req1 = 1'b0;
        chk("rstmid_reissue_ack", 32'(ack_at), 4);
        chk("rstmid_reissue_rdata", 32'(b_rdata), 'h3C);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Shares the single data memory port of the 8-bit processor between two requesters: requester 0 (processor datapath load/store path) and requester 1 (loader/debug DMA). Each requester issues one read or write at a time over a req/ack handshake; the arbiter selects a winner, drives the memory control, address and write-data lines for a configurable number of cycles, captures read data and returns a one-cycle acknowledge. It sits between the datapath's memory-access logic and the data memory, and is the only driver of the memory's read/write strobes.

## Interface
- ADDR_W, 8, memory address width
- DATA_W, 8, memory data width
- MEM_LAT, 1, cycles the memory access is held before capture; legal range 1..4
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- req0, req1  input  1 each  access request; held high with stable fields until ack
- we0, we1  input  1 each  1 = write, 0 = read
- addr0, addr1  input  ADDR_W each  access address
- wdata0, wdata1  input  DATA_W each  write data
- ack0, ack1  output  1 each  one-cycle completion pulse
- rdata  output  DATA_W  captured read data; valid while ack0 or ack1 is high
- mem_addr  output  ADDR_W  to memory address
- mem_wdata  output  DATA_W  to memory write data
- mem_read, mem_write  output  1 each  memory strobes
- mem_rdata  input  DATA_W  from memory read data (combinational)
- busy  output  1  high in ACCESS and DONE
- grant_id  output  1  requester owning the current or last transaction

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: if any req high, pick winner, latch its we/addr/wdata and id, load cycle counter with MEM_LAT-1, go ACCESS. No req: stay IDLE.
- ACCESS: mem_addr/mem_wdata from latched fields; mem_read = !we, mem_write = we, held every ACCESS cycle. Counter decrements; at zero, capture mem_rdata into rdata (reads only; writes leave rdata unchanged), go DONE.
- DONE: ack of granted requester high for exactly this cycle; go IDLE.
- Outside ACCESS: mem_read, mem_write, mem_addr, mem_wdata all 0.
- Tie (both req in IDLE): resolved per Configuration. Single req: granted regardless of history.
- req seen high in IDLE is always a new transaction; requester must drop req in the cycle following ack or it is re-granted.
- req dropped or fields changed during ACCESS/DONE: ignored; latched transaction completes and is acked.
- Reset values: state IDLE, ack0/ack1 0, rdata 0, busy 0, grant_id 0, all mem_* outputs 0, counter 0, last-grant register 1.
- Reset asserted mid-transaction: immediately returns to IDLE, no ack issued; a write whose strobe saw at least one clock edge is considered committed.

## Timing
- Request high at edge k (IDLE) -> ACCESS edges k+1..k+MEM_LAT -> ack high in cycle following edge k+MEM_LAT+1 -> IDLE.
- Request-to-ack latency MEM_LAT+1 cycles; back-to-back throughput one transaction per MEM_LAT+2 cycles.
- rdata registered, stable from DONE until next read capture.
- All outputs registered or decoded from registered state; no combinational path from req to mem_* or ack.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: on a tie the requester not granted last wins; last-grant register updated on every grant (reset value 1, so requester 0 wins the first tie).
- Undefined: fixed priority, requester 0 always wins a tie; last-grant register still exists but does not affect selection. Requester 1 can starve under continuous requester-0 traffic; this is accepted.

## Structure
- Package mem_arb_pkg: state enum (IDLE, ACCESS, DONE), requester-id typedef, MEM_LAT bounds constants.
- Sub-module arb_pick: combinational winner selection from req0, req1, last-grant and the mode; instantiated once.

## Test plan
- Reset, then req0 write addr 0x10 data 0xA5, MEM_LAT=1 -> mem_write high one cycle with mem_addr 0x10, ack0 two cycles after req; subsequent req1 read 0x10 -> rdata 0xA5 with ack1.
- MEM_LAT=3, req1 read 0x20 holding 0x3C -> mem_read high 3 cycles, ack1 in cycle 4, rdata 0x3C.
- Both req held continuously, MEM_ARB_ROUND_ROBIN_EN defined -> grants alternate 0,1,0,1; undefined -> ack0 only, ack1 never.
- req0 read 0x05 with addr changed to 0x06 during ACCESS -> mem_addr stays 0x05, ack0 still issued.
- rst low during ACCESS of a req1 read -> all outputs 0 immediately, no ack1; after release req1 re-issued completes normally.
- Req held high after ack0 -> second identical transaction granted, ack0 again MEM_LAT+2 cycles later.
